dds_sweep_ctrl: RTL and testbench

- Upstream control stage for the DDS phase-accumulator core.
- Generates the 32-bit frequency tuning word k and the DDS enable.
- Sweeps k linearly from a start word to a stop word in fixed steps, holding each value for a programmable dwell.
- Supports single-shot, repeating-sawtooth and triangle sweeps, with a start/abort pulse interface for the host.

---
 rtl/dds_pkg.sv | 18 +
 rtl/dds_dwell_timer.sv | 37 +++
 rtl/dds_sweep_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller: mode encodings, sweep
// state enum and the default tuning-word width.
package dds_pkg;

    localparam int ACC_W_DEFAULT = 32;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_REPEAT = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } sweep_state_e;

endpackage : dds_pkg

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that times how long each tuning word is held.
// zero_o flags the last cycle of the current dwell.
module dds_dwell_timer #(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge value, independent of process ordering in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : dds_dwell_timer

// File: rtl/dds_sweep_ctrl.sv
// Sweep controller feeding the DDS tuning word: linear single, sawtooth or
// triangle sweeps between a start and stop word with a per-step dwell.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int DWELL_W = 24,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ACC_W-1:0]   cfg_start_k_i,
    input  logic [ACC_W-1:0]   cfg_stop_k_i,
    input  logic [ACC_W-1:0]   cfg_step_k_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic               start_i,
    input  logic               abort_i,
    output logic [ACC_W-1:0]   k_o,
    output logic               dds_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   sweep_cnt_o
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    sweep_state_e       state_q, state_d;
    logic [ACC_W-1:0]   k_q, k_d;
    logic               dds_en_q, dds_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   sweep_cnt_q, sweep_cnt_d;

    logic [ACC_W-1:0]   start_k_q, start_k_d;
    logic [ACC_W-1:0]   stop_k_q, stop_k_d;
    logic [ACC_W-1:0]   step_k_q, step_k_d;
    logic [DWELL_W-1:0] dwell_rl_q, dwell_rl_d;
    logic [1:0]         mode_q, mode_d;

    logic               dwell_load;
    logic [DWELL_W-1:0] dwell_val;
    logic               dwell_zero;

    logic               cfg_bad;
    logic [DWELL_W-1:0] cfg_dwell_rl;
    logic [ACC_W:0]     up_next;
    logic [ACC_W:0]     dn_next;
    logic [ACC_W-1:0]   up_clamped;
    logic [ACC_W-1:0]   dn_clamped;

    assign cfg_bad = (cfg_start_k_i > cfg_stop_k_i) ||
                     (cfg_step_k_i == '0) ||
                     (cfg_mode_i == MODE_RSVD);

    // A programmed dwell of 0 behaves like 1: the counter reload is dwell-1.
    assign cfg_dwell_rl = (cfg_dwell_i == '0) ? '0 : (cfg_dwell_i - DWELL_ONE);

    // One extra bit keeps the carry/borrow so clamping never sees a wrapped word.
    assign up_next    = {1'b0, k_q} + {1'b0, step_k_q};
    assign dn_next    = {1'b0, k_q} - {1'b0, step_k_q};
    assign up_clamped = (up_next > {1'b0, stop_k_q}) ? stop_k_q : up_next[ACC_W-1:0];
    assign dn_clamped = ($signed(dn_next) < $signed({1'b0, start_k_q})) ?
                        start_k_q : dn_next[ACC_W-1:0];

    dds_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (dwell_load),
        .load_val_i (dwell_val),
        .zero_o     (dwell_zero)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        dds_en_d    = dds_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        sweep_cnt_d = sweep_cnt_q;
        start_k_d   = start_k_q;
        stop_k_d    = stop_k_q;
        step_k_d    = step_k_q;
        dwell_rl_d  = dwell_rl_q;
        mode_d      = mode_q;
        dwell_load  = 1'b0;
        dwell_val   = dwell_rl_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        start_k_d   = cfg_start_k_i;
                        stop_k_d    = cfg_stop_k_i;
                        step_k_d    = cfg_step_k_i;
                        dwell_rl_d  = cfg_dwell_rl;
                        mode_d      = cfg_mode_i;
                        k_d         = cfg_start_k_i;
                        dds_en_d    = 1'b1;
                        busy_d      = 1'b1;
                        sweep_cnt_d = '0;
                        state_d     = ST_UP;
                        dwell_load  = 1'b1;
                        dwell_val   = cfg_dwell_rl;
                    end
                end
            end

            ST_UP: begin
                if (abort_i) begin
                    state_d  = ST_IDLE;
                    k_d      = '0;
                    dds_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (dwell_zero) begin
                    dwell_load = 1'b1;
                    if (k_q == stop_k_q) begin
                        sweep_cnt_d = sweep_cnt_q + CNT_ONE;
                        unique case (mode_q)
                            MODE_REPEAT: k_d = start_k_q;
                            MODE_TRI: begin
                                // A zero-span triangle stays put and counts every dwell.
                                if (start_k_q != stop_k_q) begin
                                    k_d     = dn_clamped;
                                    state_d = ST_DOWN;
                                end
                            end
                            default: begin
                                state_d    = ST_IDLE;
                                k_d        = '0;
                                dds_en_d   = 1'b0;
                                busy_d     = 1'b0;
                                done_d     = 1'b1;
                                dwell_load = 1'b0;
                            end
                        endcase
                    end else begin
                        k_d = up_clamped;
                    end
                end
            end

            ST_DOWN: begin
                if (abort_i) begin
                    state_d  = ST_IDLE;
                    k_d      = '0;
                    dds_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (dwell_zero) begin
                    dwell_load = 1'b1;
                    if (k_q == start_k_q) begin
                        k_d     = up_clamped;
                        state_d = ST_UP;
                    end else begin
                        k_d = dn_clamped;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                k_d      = '0;
                dds_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            dds_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sweep_cnt_q <= '0;
            start_k_q   <= '0;
            stop_k_q    <= '0;
            step_k_q    <= '0;
            dwell_rl_q  <= '0;
            mode_q      <= MODE_SINGLE;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            dds_en_q    <= dds_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sweep_cnt_q <= sweep_cnt_d;
            start_k_q   <= start_k_d;
            stop_k_q    <= stop_k_d;
            step_k_q    <= step_k_d;
            dwell_rl_q  <= dwell_rl_d;
            mode_q      <= mode_d;
        end
    end

    assign k_o         = k_q;
    assign dds_en_o    = dds_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign sweep_cnt_o = sweep_cnt_q;

endmodule : dds_sweep_ctrl

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed tuning-word sequences for
// each sweep mode, clamping, rejections, abort and asynchronous reset.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_start_k_i;
    logic [31:0] cfg_stop_k_i;
    logic [31:0] cfg_step_k_i;
    logic [23:0] cfg_dwell_i;
    logic [1:0]  cfg_mode_i;
    logic        start_i;
    logic        abort_i;
    logic [31:0] k_o;
    logic        dds_en_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] sweep_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    dds_sweep_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start_k_i (cfg_start_k_i),
        .cfg_stop_k_i  (cfg_stop_k_i),
        .cfg_step_k_i  (cfg_step_k_i),
        .cfg_dwell_i   (cfg_dwell_i),
        .cfg_mode_i    (cfg_mode_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .k_o           (k_o),
        .dds_en_o      (dds_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .sweep_cnt_o   (sweep_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic next();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input logic [31:0] cnt);
        check({tag, "_k"}, k_o, 32'd0);
        check({tag, "_en"}, 32'(dds_en_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_cnt"}, 32'(sweep_cnt_o), cnt);
    endtask

    // Presents a config with a one-cycle start; returns in cycle 1.
    task automatic pulse_start(input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] st, input logic [23:0] dw,
                               input logic [1:0] md);
        cfg_start_k_i = s;
        cfg_stop_k_i  = e;
        cfg_step_k_i  = st;
        cfg_dwell_i   = dw;
        cfg_mode_i    = md;
        start_i       = 1'b1;
        next();
        start_i       = 1'b0;
    endtask

    task automatic scramble_cfg();
        cfg_start_k_i = 32'd7;
        cfg_stop_k_i  = 32'd9999;
        cfg_step_k_i  = 32'd1;
        cfg_dwell_i   = 24'd50;
        cfg_mode_i    = 2'b01;
    endtask

    task automatic run_single(input string tag);
        pulse_start(32'd100, 32'd400, 32'd100, 24'd3, 2'b00);
        scramble_cfg();
        check({tag, "_cnt_c1"}, 32'(sweep_cnt_o), 32'd0);
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("%s_k_c%0d", tag, c), k_o, 32'(100 * ((c - 1) / 3 + 1)));
            check($sformatf("%s_busy_c%0d", tag, c), 32'(busy_o), 32'd1);
            check($sformatf("%s_en_c%0d", tag, c), 32'(dds_en_o), 32'd1);
            check($sformatf("%s_done_c%0d", tag, c), 32'(done_o), 32'd0);
            next();
        end
        check({tag, "_done_c13"}, 32'(done_o), 32'd1);
        check_idle({tag, "_c13"}, 32'd1);
        next();
        check({tag, "_done_c14"}, 32'(done_o), 32'd0);
    endtask

    task automatic abort_now();
        abort_i = 1'b1;
        next();
        abort_i = 1'b0;
    endtask

    initial begin
        logic [31:0] clamp_k [3];
        logic [31:0] tri_k   [8];
        logic [31:0] tri_cnt [8];
        logic [31:0] rep_k   [9];

        clamp_k = '{32'hFFFFFF00, 32'hFFFFFF80, 32'hFFFFFFFF};
        tri_k   = '{32'd10, 32'd20, 32'd30, 32'd20, 32'd10, 32'd20, 32'd30, 32'd20};
        tri_cnt = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
        rep_k   = '{32'd10, 32'd10, 32'd20, 32'd20, 32'd30, 32'd30, 32'd10, 32'd10, 32'd20};

        rst_n   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        scramble_cfg();
        #12;
        check_idle("reset", 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        next();
        rst_n = 1'b1;
        next();

        run_single("single");

        // Clamp at top of the 32-bit range, no wrap.
        pulse_start(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 24'd1, 2'b00);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("clamp_k_c%0d", c + 1), k_o, clamp_k[c]);
            next();
        end
        check("clamp_done", 32'(done_o), 32'd1);
        check_idle("clamp_end", 32'd1);
        next();

        // Triangle, dwell 0 acts as 1; a start while busy is ignored silently.
        pulse_start(32'd10, 32'd30, 32'd10, 24'd0, 2'b10);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("tri_k_c%0d", c + 1), k_o, tri_k[c]);
            check($sformatf("tri_cnt_c%0d", c + 1), 32'(sweep_cnt_o), tri_cnt[c]);
            check($sformatf("tri_err_c%0d", c + 1), 32'(err_o), 32'd0);
            if (c == 2) begin
                cfg_mode_i = 2'b11;
                start_i    = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            next();
        end
        start_i = 1'b0;
        abort_now();
        check_idle("tri_abort", 32'd2);
        check("tri_abort_done", 32'(done_o), 32'd0);
        next();

        // Repeating sawtooth, abort while k=20.
        pulse_start(32'd10, 32'd30, 32'd10, 24'd2, 2'b01);
        for (int c = 0; c < 9; c++) begin
            check($sformatf("rep_k_c%0d", c + 1), k_o, rep_k[c]);
            if (c < 8) next();
        end
        check("rep_cnt_c9", 32'(sweep_cnt_o), 32'd1);
        abort_now();
        check_idle("rep_abort", 32'd1);
        check("rep_abort_done", 32'(done_o), 32'd0);
        next();
        check("rep_abort_done2", 32'(done_o), 32'd0);

        // Rejected starts: err pulses once, everything else holds.
        pulse_start(32'd500, 32'd100, 32'd10, 24'd1, 2'b00);
        check("rej_order_err", 32'(err_o), 32'd1);
        check_idle("rej_order", 32'd1);
        next();
        check("rej_order_err2", 32'(err_o), 32'd0);
        check("rej_order_busy2", 32'(busy_o), 32'd0);
        pulse_start(32'd100, 32'd500, 32'd0, 24'd1, 2'b00);
        check("rej_step_err", 32'(err_o), 32'd1);
        check_idle("rej_step", 32'd1);
        pulse_start(32'd100, 32'd500, 32'd10, 24'd1, 2'b11);
        check("rej_mode_err", 32'(err_o), 32'd1);
        check_idle("rej_mode", 32'd1);
        abort_i = 1'b1;
        pulse_start(32'd100, 32'd500, 32'd10, 24'd1, 2'b00);
        abort_i = 1'b0;
        check("start_abort_err", 32'(err_o), 32'd0);
        check_idle("start_abort", 32'd1);
        next();
        check("start_abort_busy2", 32'(busy_o), 32'd0);

        // Degenerate span: single gives one dwell then done.
        pulse_start(32'd50, 32'd50, 32'd5, 24'd2, 2'b00);
        check("degen_s_k_c1", k_o, 32'd50);
        next();
        check("degen_s_k_c2", k_o, 32'd50);
        next();
        check("degen_s_done", 32'(done_o), 32'd1);
        check_idle("degen_s_end", 32'd1);

        // Degenerate triangle: k constant, count steps every dwell.
        pulse_start(32'd50, 32'd50, 32'd5, 24'd1, 2'b10);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("degen_t_k_c%0d", c + 1), k_o, 32'd50);
            check($sformatf("degen_t_cnt_c%0d", c + 1), 32'(sweep_cnt_o), 32'(c));
            next();
        end
        abort_now();
        check_idle("degen_t_abort", 32'd4);

        // Asynchronous reset mid-sweep, then the single sweep again.
        pulse_start(32'd100, 32'd400, 32'd100, 24'd3, 2'b00);
        next();
        next();
        next();
        check("rst_pre_k", k_o, 32'd200);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("rst_async", 32'd0);
        check("rst_async_done", 32'(done_o), 32'd0);
        check("rst_async_err", 32'(err_o), 32'd0);
        next();
        rst_n = 1'b1;
        next();
        run_single("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dds_sweep_ctrl
